image_read: RTL and testbench

- Read-side counterpart of the image write stage.
- Walks a configured address range of the image buffer memory, issues reads, and re-streams the returned words as a valid/ready image stream to the convolution datapath.
- Sits between the image buffer memory read port and the downstream compute stage.
- Configured over the shared cfg bus; each run is launched by a `next` pulse.

---
 rtl/image_pkg.sv | 16 +
 rtl/image_read_fifo.sv | 51 +++++
 rtl/image_read.sv | 145 ++++++++++++++
 tb/tb_image_read.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared definitions for the image buffer read/write stages: config register
// indices and the read-side FSM state encoding.
package image_pkg;

  localparam logic [4:0] CFG_IMG_WR_START  = 5'd2;
  localparam logic [4:0] CFG_IMG_WR_LENGTH = 5'd3;
  localparam logic [4:0] CFG_IMG_RD_START  = 5'd4;
  localparam logic [4:0] CFG_IMG_RD_LENGTH = 5'd5;

  typedef enum logic [1:0] {
    IMG_RD_IDLE  = 2'd0,
    IMG_RD_RUN   = 2'd1,
    IMG_RD_DRAIN = 2'd2
  } img_rd_state_t;

endpackage

// File: rtl/image_read_fifo.sv
// Synchronous FIFO with fall-through head: a push into an empty FIFO is visible
// on the head the same cycle, and bypasses storage when popped immediately.
module image_read_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_vld,
  input  logic [WIDTH-1:0]               push_dat,
  output logic                           head_vld,
  output logic [WIDTH-1:0]               head_dat,
  input  logic                           pop_rdy,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             empty;
  logic             bypass;
  logic             do_wr;
  logic             do_rd;

  assign empty    = (count == '0);
  assign head_vld = !empty || push_vld;
  assign head_dat = !empty ? mem[rptr] : (push_vld ? push_dat : '0);
  assign bypass   = empty && push_vld && pop_rdy;
  assign do_wr    = push_vld && !bypass;
  assign do_rd    = pop_rdy && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
      if (do_rd) rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

endmodule

// File: rtl/image_read.sv
// Streams a configured address range of the image buffer to the compute stage.
// First word MEM_LAT+1 cycles after next; reads are credit-limited so a stalled consumer never overflows the return FIFO.
module image_read
  import image_pkg::*;
#(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int DEPTH_NB   = 16,
  parameter int IMG_WIDTH  = 16,
  parameter int MEM_AWIDTH = 16,
  parameter int MEM_LAT    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CFG_DWIDTH-1:0]         cfg_data,
  input  logic [CFG_AWIDTH-1:0]         cfg_addr,
  input  logic                          cfg_valid,
  input  logic                          next,
  output logic                          busy,
  output logic                          rd_val,
  output logic [MEM_AWIDTH-1:0]         rd_addr,
  input  logic [IMG_WIDTH*DEPTH_NB-1:0] rd_data,
  output logic [IMG_WIDTH*DEPTH_NB-1:0] str_img_bus,
  output logic                          str_img_val,
  input  logic                          str_img_rdy
);

  localparam int DW         = IMG_WIDTH * DEPTH_NB;
  localparam int FIFO_DEPTH = MEM_LAT + 2;
  localparam int CW         = $clog2(FIFO_DEPTH + 1);
  localparam int SW         = CW + 1;
  localparam int LW         = MEM_AWIDTH + 1;

  img_rd_state_t         state, state_nxt;
  logic [MEM_AWIDTH-1:0] start_sh, addr, addr_nxt;
  logic [LW-1:0]         len_sh, remaining, rem_nxt;
  logic                  pending, pending_nxt;
  logic [MEM_LAT-1:0]    vpipe;
  logic                  ret_val;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         fifo_count;
  logic                  credit_ok;
  logic                  drained;
  logic                  unused_cfg_hi;

  assign unused_cfg_hi = ^cfg_data[CFG_DWIDTH-1:MEM_AWIDTH+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      start_sh <= '0;
      len_sh   <= '0;
    end else if (cfg_valid) begin
      if (cfg_addr == CFG_AWIDTH'(CFG_IMG_RD_START))  start_sh <= cfg_data[MEM_AWIDTH-1:0];
      if (cfg_addr == CFG_AWIDTH'(CFG_IMG_RD_LENGTH)) len_sh   <= cfg_data[MEM_AWIDTH:0];
    end
  end

  // In-flight reads plus buffered words may never exceed the FIFO depth.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < SW'(FIFO_DEPTH);
  assign drained   = (outstanding == '0) && (fifo_count == '0);
  assign busy      = (state != IMG_RD_IDLE);
  assign rd_addr   = addr;

  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr;
    rem_nxt     = remaining;
    pending_nxt = pending;
    rd_val      = 1'b0;
    unique case (state)
      IMG_RD_IDLE: begin
        if (next && (len_sh != '0)) begin
          state_nxt = IMG_RD_RUN;
          addr_nxt  = start_sh;
          rem_nxt   = len_sh;
        end
      end
      IMG_RD_RUN: begin
        rd_val = (remaining != '0) && credit_ok;
        if (rd_val) begin
          addr_nxt = addr + MEM_AWIDTH'(1);
          rem_nxt  = remaining - LW'(1);
          if (remaining == LW'(1)) state_nxt = IMG_RD_DRAIN;
        end
      end
      IMG_RD_DRAIN: begin
        if (drained) begin
          pending_nxt = 1'b0;
          if (pending && (len_sh != '0)) begin
            state_nxt = IMG_RD_RUN;
            addr_nxt  = start_sh;
            rem_nxt   = len_sh;
          end else begin
            state_nxt = IMG_RD_IDLE;
          end
        end
      end
      default: state_nxt = IMG_RD_IDLE;
    endcase
    // A launch request during a run is remembered once; extras are dropped.
    if (next && busy) pending_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IMG_RD_IDLE;
      addr      <= '0;
      remaining <= '0;
      pending   <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      remaining <= rem_nxt;
      pending   <= pending_nxt;
    end
  end

  // Bit MEM_LAT-1 marks the cycle the memory presents data for a read.
  assign ret_val = vpipe[MEM_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe       <= '0;
      outstanding <= '0;
    end else begin
      vpipe       <= (vpipe << 1) | MEM_LAT'(rd_val);
      outstanding <= outstanding + CW'(rd_val) - CW'(ret_val);
    end
  end

  image_read_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (ret_val),
    .push_dat (rd_data),
    .head_vld (str_img_val),
    .head_dat (str_img_bus),
    .pop_rdy  (str_img_rdy),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_image_read.sv
// Scoreboard bench for image_read: expected addresses and words are queued as
// runs are launched and checked as the DUT issues reads and emits stream words.
module tb_image_read;
  import image_pkg::*;

  localparam int DW = 256;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   cfg_data;
  logic [4:0]    cfg_addr;
  logic          cfg_valid;
  logic          next;
  logic          busy;
  logic          rd_val;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] str_img_bus;
  logic          str_img_val;
  logic          str_img_rdy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_issued = 0;
  int words_out = 0;
  int first_val_cyc = -1;

  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_q[$];
  logic          stall_prev = 1'b0;
  logic [DW-1:0] held;

  logic [AW-1:0] a1;
  logic          v1;

  always #5 clk = ~clk;

  image_read dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_data    (cfg_data),
    .cfg_addr    (cfg_addr),
    .cfg_valid   (cfg_valid),
    .next        (next),
    .busy        (busy),
    .rd_val      (rd_val),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .str_img_bus (str_img_bus),
    .str_img_val (str_img_val),
    .str_img_rdy (str_img_rdy)
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int k = 0; k < 16; k++) w[k*16 +: 16] = a + 16'(k * 257);
    return w;
  endfunction

  // Memory with two cycles of read latency; junk when no read returns.
  always @(posedge clk) begin
    a1      <= rd_addr;
    v1      <= rd_val;
    rd_data <= v1 ? mem_word(a1) : {16{16'hDEAD}};
  end

  task automatic tick();
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    int inflight;
    @(negedge clk);
    inflight = rd_issued - words_out;
    if (rd_val === 1'b1) begin
      checks++;
      if (exp_addr_q.size() == 0) begin
        errors++;
        $display("FAIL rd_addr: unexpected read of %h with none pending", rd_addr);
      end else begin
        ea = exp_addr_q.pop_front();
        if (rd_addr !== ea) begin
          errors++;
          $display("FAIL rd_addr: got %h expected %h", rd_addr, ea);
        end
      end
      checks++;
      if (inflight >= 4) begin
        errors++;
        $display("FAIL credit: read issued with %0d in flight, limit 4", inflight);
      end
      rd_issued++;
    end
    if (stall_prev) begin
      checks++;
      if (str_img_val !== 1'b1 || str_img_bus !== held) begin
        errors++;
        $display("FAIL stall_hold: val=%b bus=%h expected val=1 bus=%h", str_img_val, str_img_bus, held);
      end
    end
    if (str_img_val === 1'b1 && first_val_cyc < 0) first_val_cyc = cyc;
    if (str_img_val === 1'b1 && str_img_rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream: unexpected word %h", str_img_bus);
      end else begin
        ew = exp_q.pop_front();
        if (str_img_bus !== ew) begin
          errors++;
          $display("FAIL stream: got %h expected %h", str_img_bus, ew);
        end
      end
      words_out++;
    end
    stall_prev = (str_img_val === 1'b1) && !str_img_rdy;
    held = str_img_bus;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    cfg_addr  = a;
    cfg_data  = d;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_next();
    next = 1'b1;
    tick();
    next = 1'b0;
  endtask

  task automatic expect_run(input logic [AW-1:0] start, input int len);
    for (int i = 0; i < len; i++) begin
      exp_addr_q.push_back(start + 16'(i));
      exp_q.push_back(mem_word(start + 16'(i)));
    end
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((busy === 1'b1 || exp_q.size() != 0) && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL wait_idle: still busy=%b with %0d words owed after %0d cycles", busy, exp_q.size(), n);
    end
  endtask

  task automatic check_run_done(input string name, input int got, input int want);
    checks++;
    if (got != want || exp_q.size() != 0 || exp_addr_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: words=%0d (want %0d) owed_words=%0d owed_reads=%0d busy=%b (want 0)",
               name, got, want, exp_q.size(), exp_addr_q.size(), busy);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (busy !== 1'b0 || rd_val !== 1'b0 || rd_addr !== '0 || str_img_val !== 1'b0 || str_img_bus !== '0) begin
      errors++;
      $display("FAIL %s: busy=%b rd_val=%b rd_addr=%h str_img_val=%b bus_nonzero=%b, all required 0",
               name, busy, rd_val, rd_addr, str_img_val, (str_img_bus != '0));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    check_outputs_zero("reset_outputs");
    rst = 1'b0;
    tick();
    check_outputs_zero("after_reset_outputs");
  endtask

  task automatic test_basic();
    int w0, pc;
    str_img_rdy = 1'b1;
    cfg_write(CFG_IMG_RD_START, 32'h0000_0010);
    cfg_write(CFG_IMG_RD_LENGTH, 32'd8);
    cfg_write(5'd2, 32'h0000_0FFF);
    cfg_write(5'd6, 32'h0000_0003);
    expect_run(16'h0010, 8);
    w0 = words_out;
    first_val_cyc = -1;
    pc = cyc;
    pulse_next();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: busy=%b expected 1 the cycle after next", busy);
    end
    wait_idle(100);
    checks++;
    if (first_val_cyc - pc != 3) begin
      errors++;
      $display("FAIL basic_latency: first val %0d cycles after next, expected 3", first_val_cyc - pc);
    end
    check_run_done("basic_done", words_out - w0, 8);
  endtask

  task automatic test_backpressure();
    int w0;
    str_img_rdy = 1'b0;
    cfg_write(CFG_IMG_RD_START, 32'h0000_0200);
    cfg_write(CFG_IMG_RD_LENGTH, 32'd16);
    expect_run(16'h0200, 16);
    w0 = words_out;
    pulse_next();
    for (int i = 0; i < 24; i++) begin
      str_img_rdy = (i % 3 == 0);
      tick();
    end
    str_img_rdy = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (rd_val !== 1'b0 || (rd_issued - words_out) != 4) begin
      errors++;
      $display("FAIL bp_credit_stop: rd_val=%b in_flight=%0d, expected rd_val=0 in_flight=4",
               rd_val, rd_issued - words_out);
    end
    str_img_rdy = 1'b1;
    wait_idle(200);
    check_run_done("bp_done", words_out - w0, 16);
  endtask

  task automatic test_wrap();
    int w0;
    str_img_rdy = 1'b1;
    cfg_write(CFG_IMG_RD_START, 32'h0000_FFFE);
    cfg_write(CFG_IMG_RD_LENGTH, 32'd4);
    expect_run(16'hFFFE, 4);
    w0 = words_out;
    pulse_next();
    wait_idle(100);
    check_run_done("wrap_done", words_out - w0, 4);
  endtask

  task automatic test_zero_len();
    cfg_write(CFG_IMG_RD_LENGTH, 32'd0);
    pulse_next();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({busy, rd_val, str_img_val} !== 3'b000) begin
        errors++;
        $display("FAIL zero_len: cycle %0d busy=%b rd_val=%b val=%b, all required 0", i, busy, rd_val, str_img_val);
      end
    end
  endtask

  task automatic test_queued_next();
    int w0, r0, n;
    logic dropped;
    str_img_rdy = 1'b1;
    cfg_write(CFG_IMG_RD_START, 32'h0000_0300);
    cfg_write(CFG_IMG_RD_LENGTH, 32'd4);
    expect_run(16'h0300, 4);
    w0 = words_out;
    r0 = rd_issued;
    pulse_next();
    tick();
    cfg_write(CFG_IMG_RD_START, 32'h0000_0100);
    expect_run(16'h0100, 4);
    pulse_next();
    tick();
    pulse_next();
    dropped = 1'b0;
    n = 0;
    while (words_out - w0 < 8 && n < 100) begin
      if (busy !== 1'b1) dropped = 1'b1;
      tick();
      n++;
    end
    wait_idle(100);
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (dropped) begin
      errors++;
      $display("FAIL queued_busy: busy dropped between runs, expected it held at 1");
    end
    checks++;
    if (rd_issued - r0 != 8) begin
      errors++;
      $display("FAIL queued_reads: %0d reads issued, expected 8", rd_issued - r0);
    end
    check_run_done("queued_done", words_out - w0, 8);
  endtask

  task automatic test_reset_mid();
    int r0, n;
    str_img_rdy = 1'b1;
    cfg_write(CFG_IMG_RD_START, 32'h0000_0400);
    cfg_write(CFG_IMG_RD_LENGTH, 32'd32);
    expect_run(16'h0400, 32);
    r0 = rd_issued;
    pulse_next();
    n = 0;
    while (rd_issued - r0 < 10 && n < 50) begin
      tick();
      n++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_outputs_zero("midreset_outputs");
    exp_q.delete();
    exp_addr_q.delete();
    rd_issued  = 0;
    words_out  = 0;
    stall_prev = 1'b0;
    pulse_next();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_shadow: busy=%b after next with reset length, expected 0", busy);
    end
    for (int i = 0; i < 4; i++) tick();
    cfg_write(CFG_IMG_RD_START, 32'h0000_0500);
    cfg_write(CFG_IMG_RD_LENGTH, 32'd2);
    expect_run(16'h0500, 2);
    pulse_next();
    wait_idle(100);
    check_run_done("midreset_rerun", words_out, 2);
  endtask

  initial begin
    rst         = 1'b1;
    cfg_data    = '0;
    cfg_addr    = '0;
    cfg_valid   = 1'b0;
    next        = 1'b0;
    str_img_rdy = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_queued_next();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
